delay_addr_ctrl: RTL

Address/control generator sitting directly upstream of the 512x8 dual-port sample RAM in the signal-delay path. Turns a sample strobe and a programmable delay offset into write/read addresses and enables for the RAM, so that the RAM read port returns the sample written N strobes earlier. Tracks buffer fill so downstream logic knows when the delayed sample on the RAM output is genuine rather than stale/uninitialised memory.

---
 rtl/delay_addr_ctrl.sv | 95 +++++++++
 1 files changed

// File: rtl/delay_addr_ctrl.sv
// delay_addr_ctrl: address/enable generator for a DEPTH-entry dual-port delay RAM.
// The write pointer advances once per sample strobe. The read address trails it
// by the programmed offset, so the RAM read port returns the sample written D
// strobes earlier. A fill counter tracks whether that delayed sample is real data.
module delay_addr_ctrl #(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [ADDRESS_WIDTH-1:0] offset,
    input  logic [DATA_WIDTH-1:0]    sample_in,
    output logic                     wr_en,
    output logic                     rd_en,
    output logic [ADDRESS_WIDTH-1:0] wr_addr,
    output logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    din,
    output logic                     dout_valid,
    output logic                     filled
);

    // Buffer depth in a width that can hold it; the counter saturates at this value.
    localparam logic [ADDRESS_WIDTH:0] DEPTH = {1'b1, {ADDRESS_WIDTH{1'b0}}};

    typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

    logic [ADDRESS_WIDTH-1:0] wptr;
    logic [ADDRESS_WIDTH-1:0] off_q;
    logic [ADDRESS_WIDTH:0]   cnt;
    logic [ADDRESS_WIDTH:0]   cnt_nxt;
    logic [ADDRESS_WIDTH:0]   dly;
    logic                     off_chg;
    state_t                   state;
    state_t                   state_nxt;

    // An offset of 0 means a full-buffer delay; rd_addr == wr_addr then, and the
    // RAM's read-before-write returns the sample from DEPTH strobes ago.
    assign dly     = (off_q == '0) ? DEPTH : {1'b0, off_q};
    assign off_chg = (offset != off_q);

    assign wr_en   = en & ~rst;
    assign rd_en   = en & ~rst;
    assign wr_addr = wptr;
    assign rd_addr = wptr - off_q;
    assign din     = sample_in;

    // Fill count update: an offset change restarts the fill and takes priority.
    // The strobe that coincides with an offset change is written but not counted.
    always_comb begin
        cnt_nxt = cnt;
        if (off_chg)
            cnt_nxt = '0;
        else if (en && cnt != DEPTH)
            cnt_nxt = cnt + 1'b1;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    // Next state: enter RUN once the updated count covers the delay.
    always_comb begin
        state_nxt = state;
        if (off_chg)
            state_nxt = FILL;
        else if (state == FILL && cnt_nxt >= dly)
            state_nxt = RUN;
    end

    // FSM output.
    always_comb begin
        filled = (state == RUN);
    end

    // Datapath registers. dout_valid tracks the RAM's one-cycle read latency and
    // uses the pre-edge count, so it marks reads of previously written samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            cnt        <= '0;
            off_q      <= offset;
            dout_valid <= 1'b0;
        end else begin
            off_q      <= offset;
            cnt        <= cnt_nxt;
            dout_valid <= en & (cnt >= dly) & ~off_chg;
            if (en)
                wptr <= wptr + 1'b1;
        end
    end

endmodule
